ssrv_dmem_ahb_initiator: RTL and testbench

Synthesizable AHB-Lite master for the core data port. It turns the core's req/ack data-memory requests into single AHB-Lite transfers. It drives the dmem_h* bus that the memory responder model answers in the AHB top-level testbench. A small request FIFO decouples core issue from bus wait states, and address/data phases are pipelined per AHB-Lite.

---
 rtl/ssrv_dmem_pkg.sv | 46 ++++
 rtl/ssrv_req_fifo.sv | 55 +++++
 rtl/ssrv_dmem_ahb_initiator.sv | 121 ++++++++++++
 tb/tb_ssrv_dmem_ahb_initiator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssrv_dmem_pkg.sv
// Shared types and constants for the core data-port AHB-Lite initiator.
// Holds the request struct queued between the core and the bus.
package ssrv_dmem_pkg;

  typedef enum logic {
    DMEM_RD = 1'b0,
    DMEM_WR = 1'b1
  } type_dmem_cmd_e;

  typedef enum logic [1:0] {
    DMEM_BYTE = 2'd0,
    DMEM_HALF = 2'd1,
    DMEM_WORD = 2'd2
  } type_dmem_width_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_RDY  = 2'd1,
    DMEM_ERR  = 2'd2
  } type_dmem_resp_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    type_dmem_cmd_e   cmd;
    type_dmem_width_e width;
    logic [31:0]      addr;
    logic [31:0]      wdata;
  } type_dmem_req_s;

  // Width code 3 is folded onto word so HSIZE never advertises a 64-bit beat.
  function automatic type_dmem_width_e norm_width(input logic [1:0] w);
    return (w == 2'd3) ? DMEM_WORD : type_dmem_width_e'(w);
  endfunction

  function automatic logic [31:0] lane_rep(input type_dmem_width_e w, input logic [31:0] d);
    case (w)
      DMEM_BYTE: return {4{d[7:0]}};
      DMEM_HALF: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/ssrv_req_fifo.sv
// Small synchronous FIFO with full/empty flags and a combinational head.
// Depth may be any value >= 1; pointers wrap explicitly.
module ssrv_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ssrv_dmem_ahb_initiator.sv
// AHB-Lite master for the core data port: queued requests become single
// NONSEQ transfers with pipelined address and data phases.
module ssrv_dmem_ahb_initiator
  import ssrv_dmem_pkg::*;
#(
  parameter int         REQ_FIFO_DEPTH = 2,
  parameter logic [3:0] HPROT_VAL      = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req,
  output logic        dmem_req_ack,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic [1:0]  dmem_resp,
  output logic [3:0]  dmem_hprot,
  output logic [2:0]  dmem_hburst,
  output logic [2:0]  dmem_hsize,
  output logic [1:0]  dmem_htrans,
  output logic        dmem_hmastlock,
  output logic [31:0] dmem_haddr,
  output logic        dmem_hwrite,
  output logic [31:0] dmem_hwdata,
  input  logic        dmem_hready,
  input  logic [31:0] dmem_hrdata,
  input  logic        dmem_hresp
);

  type_dmem_req_s  push_req, head;
  logic            fifo_full, fifo_empty;
  logic            err_first, issue, pop;
  logic            dp_valid_q, dp_valid_d;
  type_dmem_cmd_e  dp_cmd_q, dp_cmd_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic [31:0]     rdata_q, rdata_d;
  type_dmem_resp_e resp_q, resp_d;

  assign push_req = '{cmd:   type_dmem_cmd_e'(dmem_cmd),
                      width: norm_width(dmem_width),
                      addr:  dmem_addr,
                      wdata: dmem_wdata};

  assign dmem_req_ack = dmem_req & ~fifo_full;

  ssrv_req_fifo #(
    .DEPTH (REQ_FIFO_DEPTH),
    .W     ($bits(type_dmem_req_s))
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (dmem_req_ack),
    .data_i  (push_req),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // First cycle of a two-cycle ERROR: the pending address phase must go IDLE.
  assign err_first = dp_valid_q & dmem_hresp & ~dmem_hready;
  assign issue     = ~fifo_empty & ~err_first;
  assign pop       = issue & dmem_hready;

  always_comb begin
    dmem_htrans = HTRANS_IDLE;
    dmem_haddr  = '0;
    dmem_hwrite = 1'b0;
    dmem_hsize  = '0;
    if (issue) begin
      dmem_htrans = HTRANS_NONSEQ;
      dmem_haddr  = head.addr;
      dmem_hwrite = (head.cmd == DMEM_WR);
      dmem_hsize  = {1'b0, head.width};
    end
  end

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_cmd_d   = dp_cmd_q;
    hwdata_d   = hwdata_q;
    rdata_d    = rdata_q;
    resp_d     = DMEM_IDLE;
    if (dp_valid_q && dmem_hready) begin
      dp_valid_d = 1'b0;
      resp_d     = dmem_hresp ? DMEM_ERR : DMEM_RDY;
      rdata_d    = (!dmem_hresp && dp_cmd_q == DMEM_RD) ? dmem_hrdata : '0;
    end
    if (pop) begin
      dp_valid_d = 1'b1;
      dp_cmd_d   = head.cmd;
      hwdata_d   = (head.cmd == DMEM_WR) ? lane_rep(head.width, head.wdata) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_q <= 1'b0;
      dp_cmd_q   <= DMEM_RD;
      hwdata_q   <= '0;
      rdata_q    <= '0;
      resp_q     <= DMEM_IDLE;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_cmd_q   <= dp_cmd_d;
      hwdata_q   <= hwdata_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
    end
  end

  assign dmem_hwdata    = hwdata_q;
  assign dmem_rdata     = rdata_q;
  assign dmem_resp      = resp_q;
  assign dmem_hprot     = HPROT_VAL;
  assign dmem_hburst    = HBURST_SINGLE;
  assign dmem_hmastlock = 1'b0;

endmodule

// File: tb/tb_ssrv_dmem_ahb_initiator.sv
// Directed self-checking bench for ssrv_dmem_ahb_initiator (FIFO depth 2).
module tb_ssrv_dmem_ahb_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmem_req = 1'b0;
  logic        dmem_req_ack;
  logic        dmem_cmd = 1'b0;
  logic [1:0]  dmem_width = 2'd0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic [3:0]  dmem_hprot;
  logic [2:0]  dmem_hburst;
  logic [2:0]  dmem_hsize;
  logic [1:0]  dmem_htrans;
  logic        dmem_hmastlock;
  logic [31:0] dmem_haddr;
  logic        dmem_hwrite;
  logic [31:0] dmem_hwdata;
  logic        dmem_hready = 1'b1;
  logic [31:0] dmem_hrdata = '0;
  logic        dmem_hresp = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ssrv_dmem_ahb_initiator #(.REQ_FIFO_DEPTH(2), .HPROT_VAL(4'b0011)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_hprot(dmem_hprot),
    .dmem_hburst(dmem_hburst), .dmem_hsize(dmem_hsize), .dmem_htrans(dmem_htrans),
    .dmem_hmastlock(dmem_hmastlock), .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite),
    .dmem_hwdata(dmem_hwdata), .dmem_hready(dmem_hready), .dmem_hrdata(dmem_hrdata),
    .dmem_hresp(dmem_hresp)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic v, input logic c, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
    dmem_req = v; dmem_cmd = c; dmem_width = w; dmem_addr = a; dmem_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    step(); step();
    #1;
    n_checks++; if (dmem_htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans got %h want 0", dmem_htrans); end
    n_checks++; if (dmem_haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr got %h want 0", dmem_haddr); end
    n_checks++; if (dmem_hwrite !== 1'b0 || dmem_hsize !== 3'd0) begin n_fail++; $display("FAIL rst_hwrite_hsize got %b/%0d want 0/0", dmem_hwrite, dmem_hsize); end
    n_checks++; if (dmem_hwdata !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata got %h want 0", dmem_hwdata); end
    n_checks++; if (dmem_resp !== 2'd0 || dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp got %0d/%h want 0/0", dmem_resp, dmem_rdata); end
    n_checks++; if (dmem_hprot !== 4'b0011 || dmem_hburst !== 3'b000 || dmem_hmastlock !== 1'b0) begin
      n_fail++; $display("FAIL rst_const got hprot %h hburst %h lock %b want 3/0/0", dmem_hprot, dmem_hburst, dmem_hmastlock); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait_read();
    dmem_hready = 1'b1; dmem_hresp = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    #1;
    n_checks++; if (dmem_req_ack !== 1'b1) begin n_fail++; $display("FAIL zw_ack got %b want 1", dmem_req_ack); end
    n_checks++; if (dmem_htrans !== 2'b00) begin n_fail++; $display("FAIL zw_htrans_c0 got %h want 0", dmem_htrans); end
    step();
    dmem_req = 1'b0;
    #1;
    n_checks++; if (dmem_htrans !== 2'b10 || dmem_haddr !== 32'h100 || dmem_hsize !== 3'd2 || dmem_hwrite !== 1'b0) begin
      n_fail++; $display("FAIL zw_addr_phase got %h %h %0d %b want 2 100 2 0", dmem_htrans, dmem_haddr, dmem_hsize, dmem_hwrite); end
    step();
    dmem_hrdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (dmem_htrans !== 2'b00 || dmem_resp !== 2'd0) begin n_fail++; $display("FAIL zw_c2 got htrans %h resp %0d want 0/0", dmem_htrans, dmem_resp); end
    step();
    dmem_hrdata = 32'h0;
    #1;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_resp got %0d/%h want 1/deadbeef", dmem_resp, dmem_rdata); end
    step();
    n_checks++; if (dmem_resp !== 2'd0) begin n_fail++; $display("FAIL zw_pulse got %0d want 0", dmem_resp); end
  endtask

  task automatic test_byte_write();
    set_req(1'b1, 1'b1, 2'd0, 32'h203, 32'h000000A5);
    step();
    dmem_req = 1'b0;
    #1;
    n_checks++; if (dmem_htrans !== 2'b10 || dmem_haddr !== 32'h203 || dmem_hsize !== 3'd0 || dmem_hwrite !== 1'b1) begin
      n_fail++; $display("FAIL bw_addr_phase got %h %h %0d %b want 2 203 0 1", dmem_htrans, dmem_haddr, dmem_hsize, dmem_hwrite); end
    step();
    #1;
    n_checks++; if (dmem_hwdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bw_hwdata got %h want a5a5a5a5", dmem_hwdata); end
    step();
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL bw_resp got %0d/%h want 1/0", dmem_resp, dmem_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    dmem_hready = 1'b1;
    set_req(1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    step();
    set_req(1'b1, 1'b1, 2'd1, 32'h22, 32'h00001234);
    #1;
    n_checks++; if (dmem_htrans !== 2'b10 || dmem_haddr !== 32'h10 || dmem_req_ack !== 1'b1) begin
      n_fail++; $display("FAIL b2b_c1 got %h %h ack %b want 2 10 1", dmem_htrans, dmem_haddr, dmem_req_ack); end
    step();
    set_req(1'b1, 1'b0, 2'd2, 32'h30, 32'h0);
    dmem_hrdata = 32'h11111111;
    #1;
    n_checks++; if (dmem_htrans !== 2'b10 || dmem_haddr !== 32'h22 || dmem_hsize !== 3'd1 || dmem_hwrite !== 1'b1) begin
      n_fail++; $display("FAIL b2b_c2 got %h %h %0d %b want 2 22 1 1", dmem_htrans, dmem_haddr, dmem_hsize, dmem_hwrite); end
    step();
    dmem_req = 1'b0; dmem_hready = 1'b0; dmem_hrdata = 32'h0;
    #1;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_resp1 got %0d/%h want 1/11111111", dmem_resp, dmem_rdata); end
    n_checks++; if (dmem_hwdata !== 32'h12341234 || dmem_haddr !== 32'h30) begin n_fail++; $display("FAIL b2b_wait1 got %h/%h want 12341234/30", dmem_hwdata, dmem_haddr); end
    step();
    #1;
    n_checks++; if (dmem_resp !== 2'd0 || dmem_htrans !== 2'b10 || dmem_haddr !== 32'h30 || dmem_hwdata !== 32'h12341234) begin
      n_fail++; $display("FAIL b2b_wait2 got resp %0d %h %h %h want 0 2 30 12341234", dmem_resp, dmem_htrans, dmem_haddr, dmem_hwdata); end
    dmem_hready = 1'b1;
    step();
    dmem_hrdata = 32'h33333333;
    #1;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'h0 || dmem_htrans !== 2'b00) begin
      n_fail++; $display("FAIL b2b_resp2 got %0d/%h htrans %h want 1/0/0", dmem_resp, dmem_rdata, dmem_htrans); end
    step();
    dmem_hrdata = 32'h0;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'h33333333) begin n_fail++; $display("FAIL b2b_resp3 got %0d/%h want 1/33333333", dmem_resp, dmem_rdata); end
    step();
  endtask

  task automatic test_error();
    dmem_hready = 1'b1; dmem_hresp = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
    step();
    set_req(1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
    step();
    dmem_req = 1'b0; dmem_hready = 1'b0; dmem_hresp = 1'b1;
    #1;
    n_checks++; if (dmem_htrans !== 2'b00 || dmem_resp !== 2'd0) begin n_fail++; $display("FAIL err_first got htrans %h resp %0d want 0/0", dmem_htrans, dmem_resp); end
    step();
    dmem_hready = 1'b1; dmem_hresp = 1'b1;
    #1;
    n_checks++; if (dmem_htrans !== 2'b10 || dmem_haddr !== 32'h8) begin n_fail++; $display("FAIL err_reissue got %h/%h want 2/8", dmem_htrans, dmem_haddr); end
    step();
    dmem_hresp = 1'b0; dmem_hrdata = 32'h88;
    #1;
    n_checks++; if (dmem_resp !== 2'd2) begin n_fail++; $display("FAIL err_resp got %0d want 2", dmem_resp); end
    step();
    dmem_hrdata = 32'h0;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'h88) begin n_fail++; $display("FAIL err_next got %0d/%h want 1/88", dmem_resp, dmem_rdata); end
    step();
  endtask

  task automatic test_mid_reset();
    dmem_hready = 1'b1;
    set_req(1'b1, 1'b1, 2'd2, 32'h40, 32'hCAFEF00D);
    step();
    dmem_req = 1'b0;
    step();
    dmem_hready = 1'b0;
    #1;
    n_checks++; if (dmem_hwdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mr_hwdata_pre got %h want cafef00d", dmem_hwdata); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (dmem_htrans !== 2'b00 || dmem_haddr !== 32'h0 || dmem_hwrite !== 1'b0 || dmem_hsize !== 3'd0 ||
                    dmem_hwdata !== 32'h0 || dmem_resp !== 2'd0 || dmem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mr_async got %h %h %b %0d %h %0d %h want all 0", dmem_htrans, dmem_haddr, dmem_hwrite,
                         dmem_hsize, dmem_hwdata, dmem_resp, dmem_rdata); end
    step();
    rst_n = 1'b1; dmem_hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (dmem_resp !== 2'd0 || dmem_htrans !== 2'b00) begin
        n_fail++; $display("FAIL mr_quiet%0d got resp %0d htrans %h want 0/0", i, dmem_resp, dmem_htrans); end
    end
  endtask

  task automatic test_full_backpressure();
    dmem_hready = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 32'h50, 32'h0);
    step();
    set_req(1'b1, 1'b0, 2'd2, 32'h54, 32'h0);
    #1;
    n_checks++; if (dmem_req_ack !== 1'b1) begin n_fail++; $display("FAIL fb_ack2 got %b want 1", dmem_req_ack); end
    step();
    set_req(1'b1, 1'b0, 2'd2, 32'h58, 32'h0);
    #1;
    n_checks++; if (dmem_req_ack !== 1'b0 || dmem_htrans !== 2'b10 || dmem_haddr !== 32'h50) begin
      n_fail++; $display("FAIL fb_full got ack %b %h %h want 0 2 50", dmem_req_ack, dmem_htrans, dmem_haddr); end
    step();
    dmem_hready = 1'b1;
    #1;
    n_checks++; if (dmem_req_ack !== 1'b0) begin n_fail++; $display("FAIL fb_nobypass got %b want 0", dmem_req_ack); end
    step();
    dmem_hrdata = 32'hA0;
    #1;
    n_checks++; if (dmem_req_ack !== 1'b1 || dmem_haddr !== 32'h54) begin n_fail++; $display("FAIL fb_after_pop got ack %b addr %h want 1/54", dmem_req_ack, dmem_haddr); end
    step();
    dmem_req = 1'b0; dmem_hrdata = 32'hB0;
    #1;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'hA0 || dmem_haddr !== 32'h58) begin
      n_fail++; $display("FAIL fb_r1 got %0d/%h addr %h want 1/a0/58", dmem_resp, dmem_rdata, dmem_haddr); end
    step();
    dmem_hrdata = 32'hC0;
    #1;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'hB0) begin n_fail++; $display("FAIL fb_r2 got %0d/%h want 1/b0", dmem_resp, dmem_rdata); end
    step();
    dmem_hrdata = 32'h0;
    n_checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'hC0) begin n_fail++; $display("FAIL fb_r3 got %0d/%h want 1/c0", dmem_resp, dmem_rdata); end
    step();
    n_checks++; if (dmem_resp !== 2'd0 || dmem_htrans !== 2'b00) begin n_fail++; $display("FAIL fb_drain got %0d/%h want 0/0", dmem_resp, dmem_htrans); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_byte_write();
    test_back_to_back();
    test_error();
    test_mid_reset();
    test_full_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
